// File: rtl/core_pkg.sv
// Shared types and constants for the memory-access stage.
//   ma_state_t      : MA state machine encoding (IDLE, REQ, WAIT)
//   MEM_OP_*        : load/store funct3 encodings
//   EXC_*           : fault cause codes reported on ma_exc_cause
//   is_misaligned() : natural-alignment test used when the misalignment
//                     check (CORE_MA_MISALIGN_CHECK_EN) is compiled in
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } ma_state_t;

  localparam logic [2:0] MEM_OP_B  = 3'b000;
  localparam logic [2:0] MEM_OP_H  = 3'b001;
  localparam logic [2:0] MEM_OP_W  = 3'b010;
  localparam logic [2:0] MEM_OP_BU = 3'b100;
  localparam logic [2:0] MEM_OP_HU = 3'b101;

  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

  // Halfwords must sit on even addresses, words on multiples of four.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr);
    case (op)
      MEM_OP_H, MEM_OP_HU: return addr[0];
      MEM_OP_W:            return addr != 2'b00;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_ma_align.sv
// Combinational lane alignment for the memory-access stage.
//   op, addr    : funct3 and low address bits of the access
//   data        : store data from the instruction
//   rdata       : raw word returned by the data bus
//   be, wdata   : byte enables and lane-replicated store data
//   rdata_ext   : selected load lane, sign- or zero-extended per op
// Halfword lanes use addr[1] only, so an unaligned halfword is truncated
// to the halfword containing it.
module core_ma_align
  import core_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{addr, 3'b000} +: 8];
  assign lane_h = rdata[{addr[1], 4'b0000} +: 16];

  always_comb begin
    be        = 4'b1111;
    wdata     = data;
    rdata_ext = rdata;
    case (op)
      MEM_OP_B, MEM_OP_BU: begin
        be        = 4'b0001 << addr;
        wdata     = {4{data[7:0]}};
        rdata_ext = (op == MEM_OP_B) ? {{24{lane_b[7]}}, lane_b} : {24'd0, lane_b};
      end
      MEM_OP_H, MEM_OP_HU: begin
        be        = 4'b0011 << {addr[1], 1'b0};
        wdata     = {2{data[15:0]}};
        rdata_ext = (op == MEM_OP_H) ? {{16{lane_h[15]}}, lane_h} : {16'd0, lane_h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/core_ma.sv
// Memory-access pipeline stage.
//   em_*    : EX/MEM register input with em_valid/em_ready handshake
//   mw_*    : MEM/WB register output (read by writeback and EX bypass)
//   dbus_*  : single-outstanding data bus (request + load response)
//   ma_exc_*: one-cycle fault pulse, cause and faulting address
// Parameter TIMEOUT_CYCLES aborts an access stuck in REQ/WAIT (0 = never).
// Macro CORE_MA_MISALIGN_CHECK_EN: when defined, misaligned H/W accesses
// fault instead of reaching the bus.
module core_ma
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        em_valid,
  output logic        em_ready,
  input  logic [31:0] em_reg_data_mem_addr,
  input  logic [31:0] em_csr_data_mem_data,
  input  logic        em_mem_read,
  input  logic        em_mem_write,
  input  logic [2:0]  em_mem_op_type,
  input  logic [4:0]  em_rd,
  input  logic        em_reg_write,
  input  logic [11:0] em_csr,
  input  logic        em_csr_write,
  output logic        mw_valid,
  output logic [4:0]  mw_rd,
  output logic        mw_reg_write,
  output logic [31:0] mw_reg_write_data,
  output logic        mw_mem_data_valid,
  output logic [11:0] mw_csr,
  output logic        mw_csr_write,
  output logic [31:0] mw_csr_data,
  output logic        dbus_req_valid,
  input  logic        dbus_req_ready,
  output logic [31:0] dbus_req_addr,
  output logic        dbus_req_write,
  output logic [31:0] dbus_req_wdata,
  output logic [3:0]  dbus_req_be,
  input  logic        dbus_rsp_valid,
  input  logic [31:0] dbus_rsp_rdata,
  output logic        ma_exc_valid,
  output logic [3:0]  ma_exc_cause,
  output logic [31:0] ma_exc_addr
);

  localparam logic [31:0] TIMEOUT_LAST =
    (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  ma_state_t   state;
  logic [31:0] addr_held;
  logic [2:0]  op_held;
  logic        store_held;
  logic [31:0] tmo_cnt;

  logic        handshake;
  logic        is_mem;
  logic        misalign;
  logic        timeout_hit;
  logic [2:0]  align_op;
  logic [1:0]  align_addr;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_rdata;

  assign em_ready  = (state == IDLE);
  assign handshake = em_valid && em_ready;
  assign is_mem    = em_mem_read || em_mem_write;

  // In IDLE the aligner shapes the incoming store; afterwards it extracts
  // the load lane using the op/address captured at the handshake.
  assign align_op   = (state == IDLE) ? em_mem_op_type : op_held;
  assign align_addr = (state == IDLE) ? em_reg_data_mem_addr[1:0] : addr_held[1:0];

  // >= rather than == so a request accepted on the last allowed cycle still
  // times out in WAIT instead of waiting forever.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt >= TIMEOUT_LAST);

`ifdef CORE_MA_MISALIGN_CHECK_EN
  assign misalign = is_mem && is_misaligned(em_mem_op_type, em_reg_data_mem_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  core_ma_align u_align (
    .op        (align_op),
    .addr      (align_addr),
    .data      (em_csr_data_mem_data),
    .rdata     (dbus_rsp_rdata),
    .be        (align_be),
    .wdata     (align_wdata),
    .rdata_ext (align_rdata)
  );

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state             <= IDLE;
      addr_held         <= '0;
      op_held           <= '0;
      store_held        <= 1'b0;
      tmo_cnt           <= '0;
      mw_valid          <= 1'b0;
      mw_rd             <= '0;
      mw_reg_write      <= 1'b0;
      mw_reg_write_data <= '0;
      mw_mem_data_valid <= 1'b0;
      mw_csr            <= '0;
      mw_csr_write      <= 1'b0;
      mw_csr_data       <= '0;
      dbus_req_valid    <= 1'b0;
      dbus_req_addr     <= '0;
      dbus_req_write    <= 1'b0;
      dbus_req_wdata    <= '0;
      dbus_req_be       <= '0;
      ma_exc_valid      <= 1'b0;
      ma_exc_cause      <= '0;
      ma_exc_addr       <= '0;
    end else begin
      ma_exc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            mw_valid     <= 1'b1;
            mw_rd        <= em_rd;
            mw_reg_write <= em_reg_write;
            mw_csr       <= em_csr;
            mw_csr_write <= em_csr_write;
            mw_csr_data  <= em_csr_data_mem_data;
            if (!is_mem) begin
              mw_reg_write_data <= em_reg_data_mem_addr;
              mw_mem_data_valid <= 1'b1;
            end else if (misalign) begin
              ma_exc_valid      <= 1'b1;
              ma_exc_cause      <= em_mem_write ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
              ma_exc_addr       <= em_reg_data_mem_addr;
              mw_reg_write      <= 1'b0;
              mw_reg_write_data <= '0;
              mw_mem_data_valid <= 1'b1;
            end else begin
              addr_held         <= em_reg_data_mem_addr;
              op_held           <= em_mem_op_type;
              store_held        <= em_mem_write;
              tmo_cnt           <= '0;
              dbus_req_valid    <= 1'b1;
              dbus_req_addr     <= {em_reg_data_mem_addr[31:2], 2'b00};
              dbus_req_write    <= em_mem_write;
              dbus_req_wdata    <= align_wdata;
              dbus_req_be       <= align_be;
              mw_reg_write_data <= '0;
              mw_mem_data_valid <= 1'b0;
              state             <= REQ;
            end
          end else begin
            mw_valid <= 1'b0;
          end
        end

        REQ, WAIT: begin
          tmo_cnt <= tmo_cnt + 32'd1;
          if (state == REQ && dbus_req_ready) begin
            dbus_req_valid <= 1'b0;
            dbus_req_write <= 1'b0;
            dbus_req_be    <= '0;
            dbus_req_wdata <= '0;
            if (store_held) begin
              mw_mem_data_valid <= 1'b1;
              state             <= IDLE;
            end else begin
              state <= WAIT;
            end
          end else if (state == WAIT && dbus_rsp_valid) begin
            // A response in the timeout cycle wins over the abort.
            mw_reg_write_data <= align_rdata;
            mw_mem_data_valid <= 1'b1;
            state             <= IDLE;
          end else if (timeout_hit) begin
            dbus_req_valid    <= 1'b0;
            dbus_req_write    <= 1'b0;
            dbus_req_be       <= '0;
            dbus_req_wdata    <= '0;
            ma_exc_valid      <= 1'b1;
            ma_exc_cause      <= store_held ? EXC_ST_FAULT : EXC_LD_FAULT;
            ma_exc_addr       <= addr_held;
            mw_reg_write      <= 1'b0;
            mw_mem_data_valid <= 1'b1;
            state             <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_ma.sv
// Directed bench for core_ma (TIMEOUT_CYCLES = 8). Expected MEM/WB results
// are queued when an instruction is issued and compared when the stage
// reports completion (mw_valid && mw_mem_data_valid).
module tb_core_ma;
  import core_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rest;
  logic        em_valid;
  logic        em_ready;
  logic [31:0] em_reg_data_mem_addr;
  logic [31:0] em_csr_data_mem_data;
  logic        em_mem_read;
  logic        em_mem_write;
  logic [2:0]  em_mem_op_type;
  logic [4:0]  em_rd;
  logic        em_reg_write;
  logic [11:0] em_csr;
  logic        em_csr_write;
  logic        mw_valid;
  logic [4:0]  mw_rd;
  logic        mw_reg_write;
  logic [31:0] mw_reg_write_data;
  logic        mw_mem_data_valid;
  logic [11:0] mw_csr;
  logic        mw_csr_write;
  logic [31:0] mw_csr_data;
  logic        dbus_req_valid;
  logic        dbus_req_ready;
  logic [31:0] dbus_req_addr;
  logic        dbus_req_write;
  logic [31:0] dbus_req_wdata;
  logic [3:0]  dbus_req_be;
  logic        dbus_rsp_valid;
  logic [31:0] dbus_rsp_rdata;
  logic        ma_exc_valid;
  logic [3:0]  ma_exc_cause;
  logic [31:0] ma_exc_addr;

  always #5 clk = ~clk;

  core_ma #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                  (clk),
    .rest                 (rest),
    .em_valid             (em_valid),
    .em_ready             (em_ready),
    .em_reg_data_mem_addr (em_reg_data_mem_addr),
    .em_csr_data_mem_data (em_csr_data_mem_data),
    .em_mem_read          (em_mem_read),
    .em_mem_write         (em_mem_write),
    .em_mem_op_type       (em_mem_op_type),
    .em_rd                (em_rd),
    .em_reg_write         (em_reg_write),
    .em_csr               (em_csr),
    .em_csr_write         (em_csr_write),
    .mw_valid             (mw_valid),
    .mw_rd                (mw_rd),
    .mw_reg_write         (mw_reg_write),
    .mw_reg_write_data    (mw_reg_write_data),
    .mw_mem_data_valid    (mw_mem_data_valid),
    .mw_csr               (mw_csr),
    .mw_csr_write         (mw_csr_write),
    .mw_csr_data          (mw_csr_data),
    .dbus_req_valid       (dbus_req_valid),
    .dbus_req_ready       (dbus_req_ready),
    .dbus_req_addr        (dbus_req_addr),
    .dbus_req_write       (dbus_req_write),
    .dbus_req_wdata       (dbus_req_wdata),
    .dbus_req_be          (dbus_req_be),
    .dbus_rsp_valid       (dbus_rsp_valid),
    .dbus_rsp_rdata       (dbus_rsp_rdata),
    .ma_exc_valid         (ma_exc_valid),
    .ma_exc_cause         (ma_exc_cause),
    .ma_exc_addr          (ma_exc_addr)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic        chk_data;
    logic [31:0] data;
    logic        exc;
    logic [3:0]  cause;
    logic [31:0] eaddr;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic push(input logic [4:0] rd, input logic rw, input logic chk_data,
                      input logic [31:0] data, input logic exc, input logic [3:0] cause,
                      input logic [31:0] eaddr);
    exp_t e;
    e.rd = rd; e.rw = rw; e.chk_data = chk_data; e.data = data;
    e.exc = exc; e.cause = cause; e.eaddr = eaddr;
    sb.push_back(e);
  endtask

  // Called at a negedge with em_ready = 1; returns one negedge later.
  task automatic issue(input logic rd_op, input logic wr_op, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic rw);
    em_valid             = 1'b1;
    em_mem_read          = rd_op;
    em_mem_write         = wr_op;
    em_mem_op_type       = op;
    em_reg_data_mem_addr = a;
    em_csr_data_mem_data = d;
    em_rd                = rd;
    em_reg_write         = rw;
    em_csr               = 12'h300 + {7'd0, rd};
    em_csr_write         = 1'b0;
    @(negedge clk);
    em_valid     = 1'b0;
    em_mem_read  = 1'b0;
    em_mem_write = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int waited);
    exp_t e;
    waited = 0;
    while (!(mw_valid && mw_mem_data_valid) && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_done"}, 32'(mw_valid && mw_mem_data_valid), 32'd1);
    check({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_rd"}, 32'(mw_rd), 32'(e.rd));
      check({tag, "_rw"}, 32'(mw_reg_write), 32'(e.rw));
      if (e.chk_data) check({tag, "_data"}, mw_reg_write_data, e.data);
      check({tag, "_exc"}, 32'(ma_exc_valid), 32'(e.exc));
      if (e.exc) begin
        check({tag, "_cause"}, 32'(ma_exc_cause), 32'(e.cause));
        check({tag, "_eaddr"}, ma_exc_addr, e.eaddr);
      end
    end
    $display("txn %s: waited %0d cycles, mw_reg_write_data=0x%08h exc=%0b",
             tag, waited, mw_reg_write_data, ma_exc_valid);
  endtask

  // Holds dbus_req_ready low for 'delay' cycles, then accepts.
  task automatic bus_accept(input string tag, input int delay);
    for (int i = 0; i < delay; i++) begin
      check({tag, "_hold"}, 32'(dbus_req_valid), 32'd1);
      @(negedge clk);
    end
    dbus_req_ready = 1'b1;
    @(negedge clk);
    dbus_req_ready = 1'b0;
    check({tag, "_reqdrop"}, 32'(dbus_req_valid), 32'd0);
  endtask

  task automatic respond(input logic [31:0] rdata);
    dbus_rsp_valid = 1'b1;
    dbus_rsp_rdata = rdata;
    @(negedge clk);
    dbus_rsp_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input int delay, input logic [31:0] rdata,
                         input logic [31:0] exp_data, input logic [4:0] rd);
    int w;
    push(rd, 1'b1, 1'b1, exp_data, 1'b0, 4'd0, 32'd0);
    issue(1'b1, 1'b0, op, a, 32'd0, rd, 1'b1);
    check({tag, "_req"}, 32'(dbus_req_valid), 32'd1);
    check({tag, "_addr"}, dbus_req_addr, {a[31:2], 2'b00});
    check({tag, "_wr"}, 32'(dbus_req_write), 32'd0);
    check({tag, "_busy"}, 32'(em_ready), 32'd0);
    bus_accept(tag, delay);
    check({tag, "_wbusy"}, 32'(em_ready), 32'd0);
    respond(rdata);
    wait_done(tag, 4, w);
    check({tag, "_lat"}, 32'(w), 32'd0);
    check({tag, "_idle"}, 32'(em_ready), 32'd1);
  endtask

  task automatic do_store(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
    int w;
    push(5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    issue(1'b0, 1'b1, op, a, d, 5'd0, 1'b0);
    check({tag, "_req"}, 32'(dbus_req_valid), 32'd1);
    check({tag, "_addr"}, dbus_req_addr, {a[31:2], 2'b00});
    check({tag, "_wr"}, 32'(dbus_req_write), 32'd1);
    check({tag, "_be"}, 32'(dbus_req_be), 32'(exp_be));
    check({tag, "_wdata"}, dbus_req_wdata, exp_wdata);
    bus_accept(tag, 0);
    wait_done(tag, 4, w);
    check({tag, "_lat"}, 32'(w), 32'd0);
  endtask

  initial begin
    int w;
    rest = 1'b1;
    em_valid = 1'b0; em_mem_read = 1'b0; em_mem_write = 1'b0;
    em_mem_op_type = 3'd0; em_reg_data_mem_addr = '0; em_csr_data_mem_data = '0;
    em_rd = '0; em_reg_write = 1'b0; em_csr = '0; em_csr_write = 1'b0;
    dbus_req_ready = 1'b0; dbus_rsp_valid = 1'b0; dbus_rsp_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_mw_valid", 32'(mw_valid), 32'd0);
    check("rst_mdv", 32'(mw_mem_data_valid), 32'd0);
    check("rst_req", 32'(dbus_req_valid), 32'd0);
    check("rst_exc", 32'(ma_exc_valid), 32'd0);
    check("rst_data", mw_reg_write_data, 32'd0);
    check("rst_ready", 32'(em_ready), 32'd1);
    rest = 1'b0;
    @(negedge clk);

    // Non-memory pass-through
    push(5'd3, 1'b1, 1'b1, 32'h0000_1234, 1'b0, 4'd0, 32'd0);
    issue(1'b0, 1'b0, MEM_OP_W, 32'h0000_1234, 32'd0, 5'd3, 1'b1);
    check("nm_ready", 32'(em_ready), 32'd1);
    check("nm_csr", 32'(mw_csr), 32'h303);
    wait_done("nm", 4, w);
    check("nm_lat", 32'(w), 32'd0);
    @(negedge clk);
    check("nm_drop", 32'(mw_valid), 32'd0);

    // Loads
    do_load("lb",  MEM_OP_B,  32'h0000_0103, 2, 32'h80FF_FFFF, 32'hFFFF_FF80, 5'd5);
    do_load("lhu", MEM_OP_HU, 32'h0000_0202, 0, 32'hBEEF_0000, 32'h0000_BEEF, 5'd6);
    do_load("lh",  MEM_OP_H,  32'h0000_0500, 1, 32'h1234_8001, 32'hFFFF_8001, 5'd7);
    do_load("lbu", MEM_OP_BU, 32'h0000_0101, 0, 32'h0000_A500, 32'h0000_00A5, 5'd8);
    do_load("lw",  MEM_OP_W,  32'h0000_0600, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd9);

    // Stores
    do_store("sb", MEM_OP_B, 32'h0000_0301, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
    do_store("sh", MEM_OP_H, 32'h0000_0302, 32'h1234_CDEF, 4'b1100, 32'hCDEF_CDEF);
    do_store("sw", MEM_OP_W, 32'h0000_0304, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    // Load timeout: accepted in cycle 1, no response, abort after cycle 8
    push(5'd10, 1'b0, 1'b0, 32'd0, 1'b1, EXC_LD_FAULT, 32'h0000_0700);
    issue(1'b1, 1'b0, MEM_OP_W, 32'h0000_0700, 32'd0, 5'd10, 1'b1);
    dbus_req_ready = 1'b1;
    @(negedge clk);
    dbus_req_ready = 1'b0;
    wait_done("to_ld", 20, w);
    check("to_ld_cycles", 32'(w), 32'd7);

    // Late response in IDLE is ignored; fault pulse lasts one cycle
    respond(32'h5555_5555);
    check("late_valid", 32'(mw_valid), 32'd0);
    check("late_exc", 32'(ma_exc_valid), 32'd0);
    check("late_ready", 32'(em_ready), 32'd1);

    // Store timeout: never accepted
    push(5'd0, 1'b0, 1'b0, 32'd0, 1'b1, EXC_ST_FAULT, 32'h0000_0710);
    issue(1'b0, 1'b1, MEM_OP_W, 32'h0000_0710, 32'h1111_1111, 5'd0, 1'b0);
    wait_done("to_st", 20, w);
    check("to_st_cycles", 32'(w), 32'd8);
    check("to_st_req", 32'(dbus_req_valid), 32'd0);

    // Response in the timeout cycle wins
    push(5'd11, 1'b1, 1'b1, 32'h1122_3344, 1'b0, 4'd0, 32'd0);
    issue(1'b1, 1'b0, MEM_OP_W, 32'h0000_0720, 32'd0, 5'd11, 1'b1);
    dbus_req_ready = 1'b1;
    @(negedge clk);
    dbus_req_ready = 1'b0;
    repeat (6) @(negedge clk);
    respond(32'h1122_3344);
    wait_done("to_race", 4, w);
    check("to_race_lat", 32'(w), 32'd0);

`ifdef CORE_MA_MISALIGN_CHECK_EN
    push(5'd12, 1'b0, 1'b0, 32'd0, 1'b1, EXC_LD_MISALIGN, 32'h0000_0402);
    issue(1'b1, 1'b0, MEM_OP_W, 32'h0000_0402, 32'd0, 5'd12, 1'b1);
    check("mis_lw_req", 32'(dbus_req_valid), 32'd0);
    wait_done("mis_lw", 2, w);
    check("mis_lw_lat", 32'(w), 32'd0);
    push(5'd0, 1'b0, 1'b0, 32'd0, 1'b1, EXC_ST_MISALIGN, 32'h0000_0403);
    issue(1'b0, 1'b1, MEM_OP_H, 32'h0000_0403, 32'h0000_BEEF, 5'd0, 1'b0);
    check("mis_sh_req", 32'(dbus_req_valid), 32'd0);
    wait_done("mis_sh", 2, w);
    check("mis_sh_lat", 32'(w), 32'd0);
`else
    do_load("mis_lw", MEM_OP_W, 32'h0000_0402, 0, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 5'd12);
    do_store("mis_sh", MEM_OP_H, 32'h0000_0403, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
`endif

    // Asynchronous reset while waiting for a load response
    issue(1'b1, 1'b0, MEM_OP_W, 32'h0000_0800, 32'd0, 5'd13, 1'b1);
    dbus_req_ready = 1'b1;
    @(negedge clk);
    dbus_req_ready = 1'b0;
    check("ars_pre_valid", 32'(mw_valid), 32'd1);
    #2 rest = 1'b1;
    #1;
    check("ars_valid", 32'(mw_valid), 32'd0);
    check("ars_rd", 32'(mw_rd), 32'd0);
    check("ars_rw", 32'(mw_reg_write), 32'd0);
    check("ars_req", 32'(dbus_req_valid), 32'd0);
    check("ars_ready", 32'(em_ready), 32'd1);
    $display("txn ars: reset asserted mid-WAIT");
    @(negedge clk);
    rest = 1'b0;
    @(negedge clk);
    check("ars_post_ready", 32'(em_ready), 32'd1);
    push(5'd14, 1'b1, 1'b1, 32'h0BAD_F00D, 1'b0, 4'd0, 32'd0);
    issue(1'b0, 1'b0, MEM_OP_W, 32'h0BAD_F00D, 32'd0, 5'd14, 1'b1);
    wait_done("ars_nm", 4, w);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
